// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration helpers for the programmable Mealy sequence detector.
package seq_det_pkg;

  localparam bit MODE_NONOVL = 1'b0;
  localparam bit MODE_OVL    = 1'b1;

  localparam int PATTERN_LEN_MIN = 2;
  localparam int PATTERN_LEN_MAX = 32;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  function automatic bit pattern_len_ok(input int len);
    return (len >= PATTERN_LEN_MIN) && (len <= PATTERN_LEN_MAX);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky flag that latches when the count first reaches all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat_sticky
);

  localparam logic [W-1:0] ALL_ONES = '1;

  logic [W-1:0] r_cnt;
  logic         r_sat;

  // NOTE: sequential state is assigned with <= so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (inc && (r_cnt != ALL_ONES)) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == (ALL_ONES - 1'b1)) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign cnt        = r_cnt;
  assign sat_sticky = r_sat;

endmodule

// File: rtl/seq_detect_prog_mealy.sv
// Programmable-pattern Mealy serial sequence detector with runtime overlap selection
// and a saturating match counter.
module seq_detect_prog_mealy
  import seq_det_pkg::*;
#(
  parameter int                     PATTERN_LEN     = 4,
  parameter logic [PATTERN_LEN-1:0] DEFAULT_PATTERN = 4'b1001,
  parameter bit                     DEFAULT_OVERLAP = MODE_NONOVL,
  parameter int                     CNT_W           = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_load,
  input  logic [PATTERN_LEN-1:0] cfg_pattern,
  input  logic                   cfg_overlap,
  input  logic                   din_valid,
  input  logic                   din,
  output logic                   dout,
  output logic [CNT_W-1:0]       match_count,
  output logic                   count_sat
);

  if (!pattern_len_ok(PATTERN_LEN)) begin : g_bad_pattern_len
    $error("seq_detect_prog_mealy: PATTERN_LEN must lie in 2..32");
  end

  localparam int                FILL_W    = clog2(PATTERN_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_LEN - 1);

  logic [PATTERN_LEN-1:0] r_pat;
  logic                   r_ovl;
  logic [PATTERN_LEN-2:0] r_hist;
  logic [FILL_W-1:0]      r_fill;

  logic [PATTERN_LEN-1:0] w_window;
  logic                   w_accept;
  logic                   w_full;
  logic                   w_match;

  // The completing bit joins the stored history so a match is flagged in the same cycle.
  assign w_window = {r_hist, din};
  assign w_accept = din_valid & ~cfg_load & ~reset;
  assign w_full   = (r_fill == FILL_FULL);
  assign w_match  = w_accept & w_full & (w_window == r_pat);
  assign dout     = w_match;

  // NOTE: only a synchronous reset is sampled here; there is no asynchronous path to any register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat  <= DEFAULT_PATTERN;
      r_ovl  <= DEFAULT_OVERLAP;
      r_hist <= '0;
      r_fill <= '0;
    end else if (cfg_load) begin
      r_pat  <= cfg_pattern;
      r_ovl  <= cfg_overlap;
      r_hist <= '0;
      r_fill <= '0;
    end else if (din_valid) begin
      r_hist <= w_window[PATTERN_LEN-2:0];
      if (w_match) begin
        // Overlap keeps the window full so the match suffix can seed the next one.
        r_fill <= (r_ovl == MODE_OVL) ? FILL_FULL : '0;
      end else if (!w_full) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk        (clk),
    .rst        (reset),
    .clr        (cfg_load),
    .inc        (w_match),
    .cnt        (match_count),
    .sat_sticky (count_sat)
  );

endmodule
